// File: rtl/ibm_pc_bus_pkg.sv
// Shared definitions for the ls374 latch-bank bus controllers.
// Holds the sequencer state encoding, the operation codes latched at grant
// time, and the legal parameter ranges of the controllers that import it.
package ibm_pc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CAP,
        ST_DRV,
        ST_TURN
    } state_e;

    localparam logic OP_DRIVE   = 1'b0;
    localparam logic OP_CAPTURE = 1'b1;

    localparam int NUM_REQ_MIN      = 2;
    localparam int NUM_REQ_MAX      = 8;
    localparam int DRIVE_CYCLES_MIN = 1;
    localparam int DRIVE_CYCLES_MAX = 15;
    localparam int TURNAROUND_MAX   = 7;

    // Wide enough for the largest drive window or turnaround count.
    localparam int CNT_W = 4;

endpackage

// File: rtl/ls374_bank_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
// Selects the first set request at or after the pointer, wrapping around.
// Ports:
//   req      - request vector
//   ptr      - index that currently has highest priority
//   gnt      - one-hot grant (all zero when no request is set)
//   gnt_idx  - encoded index of the grant (0 when no request is set)
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   gnt_idx
);

    logic found;
    int   pos;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[pos]) begin
                found        = 1'b1;
                gnt[pos]     = 1'b1;
                gnt_idx      = SEL_W'(pos);
            end
        end
    end

endmodule

// File: rtl/ls374_bank_arbiter.sv
// ls374_bank_arbiter: sequences capture and drive operations on a set of
// 4-bit ls374-style latch banks that share one tri-state nibble bus.
// Ports:
//   clk, reset_n       - system clock, asynchronous active-low reset
//   req, req_wr        - per-requester request level and op (1 capture, 0 drive)
//   gnt, done          - one-cycle one-hot grant / completion pulses
//   latch_g            - per-bank latch enable
//   latch_oe_n         - per-bank output enable, active low
//   d_sel              - shared d-input mux select
//   busy               - high whenever the sequencer is not idle
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | sample req/req_wr, pick a requester round-robin
// ST_SETUP | grant pulse; for capture, d_sel settles one cycle before g
// ST_CAP   | latch_g and done pulse for the granted bank
// ST_DRV   | granted bank's oe_n low for DRIVE_CYCLES cycles
// ST_TURN  | all oe_n high for TURNAROUND cycles, done on the last one
module ls374_bank_arbiter
    import ibm_pc_bus_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int SEL_W        = 2,
    parameter int DRIVE_CYCLES = 2,
    parameter int TURNAROUND   = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_wr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] latch_g,
    output logic [NUM_REQ-1:0] latch_oe_n,
    output logic [SEL_W-1:0]   d_sel,
    output logic               busy
);

    localparam logic [CNT_W-1:0] DRV_LOAD  = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic               op_q, op_d;

    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] latch_g_q, latch_g_d;
    logic [NUM_REQ-1:0] latch_oe_n_q, latch_oe_n_d;
    logic [SEL_W-1:0]   d_sel_q, d_sel_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [SEL_W-1:0]   arb_idx;
    logic [NUM_REQ-1:0] sel_onehot;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Next-state, counter and operation bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    idx_d   = arb_idx;
                    op_d    = |(req_wr & arb_gnt);
                    ptr_d   = (int'(arb_idx) + 1 == NUM_REQ) ? '0 : arb_idx + SEL_W'(1);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (op_q == OP_CAPTURE) begin
                    state_d = ST_CAP;
                end else begin
                    state_d = ST_DRV;
                    cnt_d   = DRV_LOAD;
                end
            end
            ST_CAP: begin
                state_d = ST_IDLE;
            end
            ST_DRV: begin
                if (cnt_q == '0) begin
                    if (TURNAROUND == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_TURN;
                        cnt_d   = TURN_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_TURN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered: they are derived from the state being entered
    // so each pulse lines up with the cycle that state occupies.
    always_comb begin
        sel_onehot   = NUM_REQ'(1) << idx_d;
        gnt_d        = '0;
        done_d       = '0;
        latch_g_d    = '0;
        latch_oe_n_d = '1;
        d_sel_d      = d_sel_q;
        busy_d       = (state_d != ST_IDLE);
        case (state_d)
            ST_SETUP: begin
                gnt_d = sel_onehot;
                if (op_d == OP_CAPTURE) begin
                    d_sel_d = idx_d;
                end
            end
            ST_CAP: begin
                latch_g_d = sel_onehot;
                done_d    = sel_onehot;
            end
            ST_DRV: begin
                latch_oe_n_d = ~sel_onehot;
                if (TURNAROUND == 0 && cnt_d == '0) begin
                    done_d = sel_onehot;
                end
            end
            ST_TURN: begin
                if (cnt_d == '0) begin
                    done_d = sel_onehot;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            ptr_q        <= '0;
            op_q         <= OP_DRIVE;
            gnt_q        <= '0;
            done_q       <= '0;
            latch_g_q    <= '0;
            latch_oe_n_q <= '1;
            d_sel_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            ptr_q        <= ptr_d;
            op_q         <= op_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            latch_g_q    <= latch_g_d;
            latch_oe_n_q <= latch_oe_n_d;
            d_sel_q      <= d_sel_d;
            busy_q       <= busy_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign latch_g    = latch_g_q;
    assign latch_oe_n = latch_oe_n_q;
    assign d_sel      = d_sel_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ls374_bank_arbiter.sv
module tb_ls374_bank_arbiter;

    localparam int DC = 2;
    localparam int TA = 1;

    typedef struct {
        logic [3:0] gnt;
        logic [3:0] done;
        logic [3:0] g;
        logic [3:0] oe;
        logic [1:0] dsel;
        logic       busy;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic [3:0] wr;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = '0, req_wr = '0;
    logic [3:0] gnt, done, latch_g, latch_oe_n;
    logic [1:0] d_sel;
    logic       busy;

    logic [3:0] req_z = '0, req_wr_z = '0;
    logic [3:0] gnt_z, done_z, latch_g_z, latch_oe_n_z;
    logic [1:0] d_sel_z;
    logic       busy_z;

    int vec_cnt = 0;
    int miss_cnt = 0;

    // reference model state: the operation in flight is described by its
    // SETUP cycle, length, bank and type; everything else follows from offsets
    int         m_s, m_len, m_idx, m_ptr;
    bit         m_cap;
    logic [1:0] m_dsel;

    always #5 clk = ~clk;

    ls374_bank_arbiter #(.NUM_REQ(4), .SEL_W(2), .DRIVE_CYCLES(DC), .TURNAROUND(TA)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_wr(req_wr),
        .gnt(gnt), .done(done), .latch_g(latch_g), .latch_oe_n(latch_oe_n),
        .d_sel(d_sel), .busy(busy));

    ls374_bank_arbiter #(.NUM_REQ(4), .SEL_W(2), .DRIVE_CYCLES(1), .TURNAROUND(0)) dut_z (
        .clk(clk), .reset_n(reset_n), .req(req_z), .req_wr(req_wr_z),
        .gnt(gnt_z), .done(done_z), .latch_g(latch_g_z), .latch_oe_n(latch_oe_n_z),
        .d_sel(d_sel_z), .busy(busy_z));

    function automatic exp_t mk(input logic [3:0] gn, input logic [3:0] dn, input logic [3:0] g,
                                input logic [3:0] oe, input logic [1:0] ds, input logic bz);
        exp_t e;
        e.gnt = gn; e.done = dn; e.g = g; e.oe = oe; e.dsel = ds; e.busy = bz;
        return e;
    endfunction

    task automatic model_reset();
        m_s = -100; m_len = 0; m_idx = 0; m_ptr = 0; m_cap = 1'b0; m_dsel = 2'd0;
    endtask

    // Expected outputs for cycle c; if the model is idle in c it also
    // arbitrates the inputs presented during c.
    task automatic model_step(input int c, input logic [3:0] r, input logic [3:0] w, output exp_t e);
        int  k, pick;
        bit  found;
        e = mk(4'h0, 4'h0, 4'h0, 4'hF, m_dsel, 1'b0);
        if (c >= m_s && c < m_s + m_len) begin
            k = c - m_s;
            e.busy = 1'b1;
            if (k == 0) begin
                e.gnt = 4'(1 << m_idx);
                if (m_cap) m_dsel = 2'(m_idx);
                e.dsel = m_dsel;
            end else if (m_cap) begin
                e.g    = 4'(1 << m_idx);
                e.done = 4'(1 << m_idx);
            end else begin
                if (k <= DC) e.oe = ~4'(1 << m_idx);
                if (k == DC + TA) e.done = 4'(1 << m_idx);
            end
        end else if (r != 4'h0) begin
            found = 1'b0;
            pick = 0;
            for (int j = 0; j < 4; j++) begin
                if (!found && r[(m_ptr + j) % 4]) begin
                    found = 1'b1;
                    pick  = (m_ptr + j) % 4;
                end
            end
            m_idx = pick;
            m_cap = w[pick];
            m_s   = c + 1;
            m_len = m_cap ? 2 : 1 + DC + TA;
            m_ptr = (pick + 1) % 4;
        end
    endtask

    task automatic check_out(input string name, input int c, input exp_t e);
        vec_cnt++;
        if ({gnt, done, latch_g, latch_oe_n, d_sel, busy} !== {e.gnt, e.done, e.g, e.oe, e.dsel, e.busy}) begin
            miss_cnt++;
            $display("FAIL %s cyc=%0d got gnt=%h done=%h g=%h oe_n=%h d_sel=%0d busy=%b want gnt=%h done=%h g=%h oe_n=%h d_sel=%0d busy=%b",
                     name, c, gnt, done, latch_g, latch_oe_n, d_sel, busy,
                     e.gnt, e.done, e.g, e.oe, e.dsel, e.busy);
        end
    endtask

    task automatic check_val(input string name, input int act, input int want);
        vec_cnt++;
        if (act != want) begin
            miss_cnt++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    // Leaves the bench at posedge+1 of the first cycle after reset (cycle 0).
    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        req = '0; req_wr = '0; req_z = '0; req_wr_z = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    vec_t tbl[9];

    initial begin
        exp_t e;
        int   q[$];
        int   lowcnt, oe_cnt, dn_cnt, gnt_cyc, hit;
        int   c_oe0, c_dn0, c_oe1;

        tbl[0] = '{4'b0010, 4'b0010, mk(4'h0, 4'h0, 4'h0, 4'hF, 2'd0, 1'b0)};
        tbl[1] = '{4'b0000, 4'b0000, mk(4'b0010, 4'h0, 4'h0, 4'hF, 2'd1, 1'b1)};
        tbl[2] = '{4'b0000, 4'b0000, mk(4'h0, 4'b0010, 4'b0010, 4'hF, 2'd1, 1'b1)};
        tbl[3] = '{4'b1000, 4'b0000, mk(4'h0, 4'h0, 4'h0, 4'hF, 2'd1, 1'b0)};
        tbl[4] = '{4'b0000, 4'b0000, mk(4'b1000, 4'h0, 4'h0, 4'hF, 2'd1, 1'b1)};
        tbl[5] = '{4'b0000, 4'b0000, mk(4'h0, 4'h0, 4'h0, 4'b0111, 2'd1, 1'b1)};
        tbl[6] = '{4'b0000, 4'b0000, mk(4'h0, 4'h0, 4'h0, 4'b0111, 2'd1, 1'b1)};
        tbl[7] = '{4'b0000, 4'b0000, mk(4'h0, 4'b1000, 4'h0, 4'hF, 2'd1, 1'b1)};
        tbl[8] = '{4'b0000, 4'b0000, mk(4'h0, 4'h0, 4'h0, 4'hF, 2'd1, 1'b0)};

        // directed table: single capture then single drive
        do_reset();
        for (int i = 0; i < 9; i++) begin
            req = tbl[i].req; req_wr = tbl[i].wr;
            @(negedge clk);
            check_out("table", i, tbl[i].e);
            next_cycle();
        end

        // round-robin with all requesters driving
        do_reset();
        req = 4'hF; req_wr = 4'h0;
        for (int c = 0; c < 60 && q.size() < 5; c++) begin
            @(negedge clk);
            lowcnt = 0;
            for (int b = 0; b < 4; b++) if (!latch_oe_n[b]) lowcnt++;
            if (lowcnt > 1) check_val("rr_oe_overlap", lowcnt, 1);
            if (done != 4'h0 && latch_oe_n != 4'hF) check_val("rr_turn_oe", int'(latch_oe_n), 15);
            for (int b = 0; b < 4; b++) if (gnt[b]) q.push_back(b);
            next_cycle();
        end
        check_val("rr_grant_count", q.size(), 5);
        for (int i = 0; i < 5; i++)
            check_val("rr_order", (i < q.size()) ? q[i] : -1, i % 4);
        req = 4'h0;

        // request withdrawn right after the grant
        do_reset();
        oe_cnt = 0; dn_cnt = 0; gnt_cyc = -1;
        for (int c = 0; c < 8; c++) begin
            req = (c == 0) ? 4'b0010 : 4'b0000; req_wr = 4'h0;
            @(negedge clk);
            if (gnt[1] && gnt_cyc < 0) gnt_cyc = c;
            if (!latch_oe_n[1]) oe_cnt++;
            if (done[1]) dn_cnt++;
            next_cycle();
        end
        check_val("wd_gnt_cycle", gnt_cyc, 1);
        check_val("wd_oe_cycles", oe_cnt, DC);
        check_val("wd_done_pulses", dn_cnt, 1);

        // reset in the middle of bank 2 driving
        do_reset();
        hit = 0;
        for (int c = 0; c < 10 && hit == 0; c++) begin
            req = (c == 0) ? 4'b0100 : 4'b0000; req_wr = 4'h0;
            @(negedge clk);
            if (latch_oe_n == 4'b1011) hit = 1;
            else next_cycle();
        end
        check_val("rst_reached_drv", hit, 1);
        reset_n = 1'b0;
        #1;
        check_val("rst_oe_n", int'(latch_oe_n), 15);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_gnt", int'(gnt), 0);
        next_cycle();
        reset_n = 1'b1;
        req = 4'b1001;
        hit = 0;
        for (int c = 0; c < 6 && hit == 0; c++) begin
            @(negedge clk);
            if (gnt != 4'h0) begin
                hit = 1;
                check_val("rst_first_grant", int'(gnt), 1);
            end
            next_cycle();
        end
        check_val("rst_grant_seen", hit, 1);
        req = 4'h0;

        // DRIVE_CYCLES=1, TURNAROUND=0: back-to-back drives on banks 0 and 1
        do_reset();
        c_oe0 = -1; c_dn0 = -1; c_oe1 = -1;
        for (int c = 0; c < 12; c++) begin
            req_z = (c == 0) ? 4'b0011 : 4'b0010; req_wr_z = 4'h0;
            @(negedge clk);
            if (!latch_oe_n_z[0] && c_oe0 < 0) c_oe0 = c;
            if (done_z[0] && c_dn0 < 0) c_dn0 = c;
            if (!latch_oe_n_z[1] && c_oe1 < 0) c_oe1 = c;
            next_cycle();
        end
        req_z = 4'h0;
        check_val("z_oe0_cycle", c_oe0, 2);
        check_val("z_done0_with_oe0", c_dn0, c_oe0);
        check_val("z_oe1_gap_ok", int'(c_oe1 >= 0 && c_oe1 - c_oe0 >= 3), 1);

        // randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                req[b]    = ($urandom_range(0, 99) < 30);
                req_wr[b] = $urandom_range(0, 1) == 1;
            end
            model_step(c, req, req_wr, e);
            @(negedge clk);
            check_out("random", c, e);
            next_cycle();
        end
        req = '0; req_wr = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
